spike_packer: RTL and testbench

SPIKE_PACKER -- requirements
Module: spike_packer

---
 rtl/snn_pkg.sv | 14 +
 rtl/spike_counter.sv | 40 ++++
 rtl/spike_packer.sv | 134 +++++++++++++
 tb/tb_spike_packer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared SNN definitions: default channel count, membrane width and packer FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package snn_pkg;

   localparam int SNN_NUM_CHANNELS = 16;
   localparam int SNN_VMEM_W       = 8;

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } packer_state_t;

endpackage

// File: rtl/spike_counter.sv
// Running total of spikes across handshaken words, saturating at 16'hFFFF.
// Latency: total updates one cycle after the word handshake.
// Backpressure: none; samples word whenever word_vld is high, clear has priority.
module spike_counter #(
   parameter int NUM_CHANNELS = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clear,
   input  logic                    word_vld,
   input  logic [NUM_CHANNELS-1:0] word,
   output logic [15:0]             total
);

   localparam int PC_W = $clog2(NUM_CHANNELS + 1);

   logic [PC_W-1:0] pop;
   logic [16:0]     sum;

   // Popcount of the word and the unsaturated next total.
   always_comb begin
      pop = '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         pop = pop + PC_W'(word[i]);
      end
      sum = {1'b0, total} + 17'(pop);
   end

   // Accumulate on each handshake, clamping at the 16-bit maximum.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         total <= '0;
      end else if (clear) begin
         total <= '0;
      end else if (word_vld) begin
         total <= sum[16] ? 16'hFFFF : sum[15:0];
      end
   end

endmodule

// File: rtl/spike_packer.sv
// Packs per-channel spike bits into a NUM_CHANNELS-wide bitmap and writes back residual vmem.
// Latency: word valid 1 cycle after the last channel accept; vmem write 1 cycle after each accept.
// Backpressure: in_ready drops while a word is held; word held stable until out_ready.
// Optional: SPIKE_PACKER_SPIKE_COUNT_EN adds the spike_total output and its counter.
module spike_packer
   import snn_pkg::*;
#(
   parameter int NUM_CHANNELS = SNN_NUM_CHANNELS,
   parameter int VMEM_W       = SNN_VMEM_W
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            clear,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [VMEM_W:0]                 conv_result,
   input  logic [VMEM_W-1:0]               vth,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [NUM_CHANNELS-1:0]         out_index,
`ifdef SPIKE_PACKER_SPIKE_COUNT_EN
   output logic [15:0]                     spike_total,
`endif
   output logic                            vmem_wr_en,
   output logic [$clog2(NUM_CHANNELS)-1:0] vmem_wr_addr,
   output logic [VMEM_W-1:0]               vmem_wr_data
);

   localparam int CH_W = $clog2(NUM_CHANNELS);
   localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CHANNELS - 1);

   packer_state_t           state_q, state_d;
   logic [CH_W-1:0]         ch_q;
   logic [NUM_CHANNELS-1:0] bitmap_q;
   logic                    accept;
   logic                    word_hs;
   logic [VMEM_W-1:0]       vmem;
   logic                    spike;
   logic [VMEM_W-1:0]       residual;

   assign vmem      = conv_result[VMEM_W:1];
   assign spike     = conv_result[0];
   // The bitmap itself is the word; it only changes in HOLD on handshake or clear.
   assign out_index = bitmap_q;
   assign accept    = in_valid && (state_q == COLLECT);
   assign word_hs   = (state_q == HOLD) && out_ready;

   // Residual membrane: subtract threshold on a spike, never going below zero.
   always_comb begin
      residual = vmem;
      if (spike) begin
         residual = (vmem >= vth) ? (vmem - vth) : '0;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= COLLECT;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and handshake outputs; clear always forces a return to COLLECT.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         COLLECT: begin
            in_ready = 1'b1;
            if (accept && (ch_q == CH_LAST)) begin
               state_d = HOLD;
            end
         end
         HOLD: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = COLLECT;
            end
         end
         default: state_d = COLLECT;
      endcase
      if (clear) begin
         state_d = COLLECT;
      end
   end

   // Channel counter and bitmap; a clear discards any same-cycle accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ch_q     <= '0;
         bitmap_q <= '0;
      end else if (clear) begin
         ch_q     <= '0;
         bitmap_q <= '0;
      end else if (accept) begin
         bitmap_q[ch_q] <= spike;
         ch_q           <= (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
      end else if (word_hs) begin
         bitmap_q <= '0;
      end
   end

   // Residual write-back, one strobe per surviving accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vmem_wr_en   <= 1'b0;
         vmem_wr_addr <= '0;
         vmem_wr_data <= '0;
      end else begin
         vmem_wr_en <= accept && !clear;
         if (accept && !clear) begin
            vmem_wr_addr <= ch_q;
            vmem_wr_data <= residual;
         end
      end
   end

`ifdef SPIKE_PACKER_SPIKE_COUNT_EN
   spike_counter #(
      .NUM_CHANNELS (NUM_CHANNELS)
   ) u_spike_counter (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear),
      .word_vld (word_hs),
      .word     (out_index),
      .total    (spike_total)
   );
`endif

endmodule

// File: tb/tb_spike_packer.sv
// Directed self-checking bench for spike_packer (default 16 channels, 8-bit vmem).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Spike-total checks run only when SPIKE_PACKER_SPIKE_COUNT_EN is defined.
module tb_spike_packer;

   logic        clk = 1'b0;
   logic        rst;
   logic        clear;
   logic        in_valid;
   logic        in_ready;
   logic [8:0]  conv_result;
   logic [7:0]  vth;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_index;
   logic        vmem_wr_en;
   logic [3:0]  vmem_wr_addr;
   logic [7:0]  vmem_wr_data;
`ifdef SPIKE_PACKER_SPIKE_COUNT_EN
   logic [15:0] spike_total;
`endif

   int checks = 0;
   int errors = 0;

   spike_packer dut (
      .clk          (clk),
      .rst          (rst),
      .clear        (clear),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .conv_result  (conv_result),
      .vth          (vth),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_index    (out_index),
`ifdef SPIKE_PACKER_SPIKE_COUNT_EN
      .spike_total  (spike_total),
`endif
      .vmem_wr_en   (vmem_wr_en),
      .vmem_wr_addr (vmem_wr_addr),
      .vmem_wr_data (vmem_wr_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One accepted beat: drive for one edge, then drop in_valid.
   task automatic send(input logic spk, input logic [7:0] vm, input logic [7:0] th);
      in_valid    = 1'b1;
      conv_result = {vm, spk};
      vth         = th;
      step();
      in_valid    = 1'b0;
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   initial begin
      rst         = 1'b1;
      clear       = 1'b0;
      in_valid    = 1'b0;
      conv_result = '0;
      vth         = '0;
      out_ready   = 1'b0;

      // Reset state
      repeat (2) step();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_index", 32'(out_index), 32'd0);
      chk("rst_wr_en", 32'(vmem_wr_en), 32'd0);
      chk("rst_wr_addr", 32'(vmem_wr_addr), 32'd0);
      chk("rst_wr_data", 32'(vmem_wr_data), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      rst = 1'b0;
      step();

      // Word with spikes on channels 0, 3, 15
      for (int i = 0; i < 16; i++) begin
         send((i == 0) || (i == 3) || (i == 15), 8'd20, 8'd10);
         if (i == 14) chk("w1_not_done", 32'(out_valid), 32'd0);
      end
      chk("w1_out_valid", 32'(out_valid), 32'd1);
      chk("w1_out_index", 32'(out_index), 32'h8009);
      chk("w1_in_ready", 32'(in_ready), 32'd0);
      chk("w1_last_addr", 32'(vmem_wr_addr), 32'd15);
      chk("w1_last_data", 32'(vmem_wr_data), 32'd10);
      handshake();
      chk("w1_hs_valid", 32'(out_valid), 32'd0);
      chk("w1_hs_in_ready", 32'(in_ready), 32'd1);
      chk("w1_hs_index", 32'(out_index), 32'd0);
      chk("w1_hs_wr_en", 32'(vmem_wr_en), 32'd0);

      // Residual arithmetic
      send(1'b1, 8'd200, 8'd150);
      chk("res_spike_en", 32'(vmem_wr_en), 32'd1);
      chk("res_spike_addr", 32'(vmem_wr_addr), 32'd0);
      chk("res_spike_data", 32'(vmem_wr_data), 32'd50);
      send(1'b0, 8'd90, 8'd150);
      chk("res_nospike_addr", 32'(vmem_wr_addr), 32'd1);
      chk("res_nospike_data", 32'(vmem_wr_data), 32'd90);
      send(1'b1, 8'd100, 8'd150);
      chk("res_sat_data", 32'(vmem_wr_data), 32'd0);
      step();
      chk("res_idle_en", 32'(vmem_wr_en), 32'd0);
      for (int i = 3; i < 16; i++) send(i == 15, 8'd20, 8'd10);
      chk("w2_out_valid", 32'(out_valid), 32'd1);
      chk("w2_out_index", 32'(out_index), 32'h8005);

      // Backpressure: hold the word 5 cycles while in_valid pulses
      for (int i = 0; i < 5; i++) begin
         in_valid    = 1'b1;
         conv_result = {8'd33, 1'b1};
         step();
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_index", 32'(out_index), 32'h8005);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_wr_en", 32'(vmem_wr_en), 32'd0);
      end
      in_valid = 1'b0;
      handshake();
      chk("bp_hs_valid", 32'(out_valid), 32'd0);
      send(1'b0, 8'd5, 8'd10);
      chk("bp_next_addr", 32'(vmem_wr_addr), 32'd0);
      step();

      // Clear after 7 accepts (counter already at 1 from the probe above)
      for (int i = 0; i < 6; i++) send(1'b0, 8'd7, 8'd10);
      chk("clr_pre_en", 32'(vmem_wr_en), 32'd1);
      chk("clr_pre_addr", 32'(vmem_wr_addr), 32'd6);
      clear       = 1'b1;
      in_valid    = 1'b1;
      conv_result = {8'd44, 1'b1};
      step();
      clear    = 1'b0;
      in_valid = 1'b0;
      chk("clr_discard_en", 32'(vmem_wr_en), 32'd0);
      chk("clr_valid", 32'(out_valid), 32'd0);
      chk("clr_index", 32'(out_index), 32'd0);
      for (int i = 0; i < 16; i++) begin
         send(1'b1, 8'd20, 8'd10);
         if (i == 0) chk("clr_first_addr", 32'(vmem_wr_addr), 32'd0);
         if (i == 14) chk("clr_not_done", 32'(out_valid), 32'd0);
      end
      chk("clr_word_valid", 32'(out_valid), 32'd1);
      chk("clr_word_index", 32'(out_index), 32'hFFFF);
      handshake();
      step();
      chk("clr_single_word", 32'(out_valid), 32'd0);

      // Asynchronous reset mid-word
      for (int i = 0; i < 10; i++) send(1'b1, 8'd20, 8'd10);
      chk("ar_pre_data", 32'(vmem_wr_data), 32'd10);
      #2 rst = 1'b1;
      #1;
      chk("ar_out_valid", 32'(out_valid), 32'd0);
      chk("ar_out_index", 32'(out_index), 32'd0);
      chk("ar_wr_en", 32'(vmem_wr_en), 32'd0);
      chk("ar_wr_addr", 32'(vmem_wr_addr), 32'd0);
      chk("ar_wr_data", 32'(vmem_wr_data), 32'd0);
      step();
      rst = 1'b0;
      for (int i = 0; i < 16; i++) begin
         send(i == 15, 8'd20, 8'd10);
         if (i == 5) chk("ar_no_partial", 32'(out_valid), 32'd0);
         if (i == 14) chk("ar_not_done", 32'(out_valid), 32'd0);
      end
      chk("ar_word_valid", 32'(out_valid), 32'd1);
      chk("ar_word_index", 32'(out_index), 32'h8000);
      handshake();

`ifdef SPIKE_PACKER_SPIKE_COUNT_EN
      // Spike total over two words
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("cnt_cleared", 32'(spike_total), 32'd0);
      for (int i = 0; i < 16; i++) send(i < 8, 8'd20, 8'd10);
      chk("cnt_w1_index", 32'(out_index), 32'h00FF);
      handshake();
      chk("cnt_after_w1", 32'(spike_total), 32'd8);
      for (int i = 0; i < 16; i++) send(i == 0, 8'd20, 8'd10);
      chk("cnt_w2_index", 32'(out_index), 32'h0001);
      handshake();
      chk("cnt_after_w2", 32'(spike_total), 32'd9);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
